// File: rtl/ula_seq.sv
// Registered signed ALU with a start/busy/done handshake.
// Single-cycle logic/add/sub/acc ops and an N_BITS-iteration shift-add signed multiply.
module ula_seq #(
    parameter int N_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] A,
    input  logic [N_BITS-1:0] B,
    input  logic [2:0]        F,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] Saida,
    output logic              FLAG_O,
    output logic              ZERO,
    output logic              NEG
);

    localparam int P_W   = 2 * N_BITS;
    localparam int CNT_W = $clog2(N_BITS) + 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_ACC = 3'b110;

    localparam logic [N_BITS-1:0] ONE_N  = 1;
    localparam logic [P_W-1:0]    ONE_P  = 1;
    localparam logic [CNT_W-1:0]  ONE_C  = 1;
    localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(N_BITS - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    function automatic logic add_ovf(input logic a, input logic b, input logic s);
        return (a == b) && (s != a);
    endfunction

    function automatic logic sub_ovf(input logic a, input logic b, input logic s);
        return (a != b) && (s != a);
    endfunction

    // Unsigned magnitude; the most-negative value maps to 2^(N_BITS-1).
    function automatic logic [N_BITS-1:0] mag(input logic [N_BITS-1:0] v);
        return v[N_BITS-1] ? ((~v) + ONE_N) : v;
    endfunction

    function automatic logic prod_ovf(input logic [P_W-1:0] p);
        return !((&p[P_W-1:N_BITS-1]) || !(|p[P_W-1:N_BITS-1]));
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [N_BITS-1:0]  res_q, res_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic [P_W-1:0]     mcand_q, mcand_d;
    logic [N_BITS-1:0]  mplier_q, mplier_d;
    logic [P_W-1:0]     prod_q, prod_d;
    logic               sign_q, sign_d;

    logic [N_BITS-1:0]  alu_res, sum, diff, acc;
    logic               alu_ovf;
    logic [P_W-1:0]     prod_nxt, prod_sgn;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        sum     = A + B;
        diff    = A - B;
        acc     = res_q + A;
        case (F)
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = add_ovf(A[N_BITS-1], B[N_BITS-1], sum[N_BITS-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf(A[N_BITS-1], B[N_BITS-1], diff[N_BITS-1]);
            end
            OP_ACC: begin
                alu_res = acc;
                alu_ovf = add_ovf(res_q[N_BITS-1], A[N_BITS-1], acc[N_BITS-1]);
            end
            default: ;
        endcase
    end

    always_comb begin
        prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
        prod_sgn = sign_q ? ((~prod_nxt) + ONE_P) : prod_nxt;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        res_d    = res_q;
        ovf_d    = ovf_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        sign_d   = sign_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (F == OP_MUL) begin
                        state_d  = S_MUL;
                        cnt_d    = '0;
                        mcand_d  = {{N_BITS{1'b0}}, mag(A)};
                        mplier_d = mag(B);
                        prod_d   = '0;
                        sign_d   = A[N_BITS-1] ^ B[N_BITS-1];
                    end else begin
                        res_d  = alu_res;
                        ovf_d  = alu_ovf;
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                prod_d   = prod_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + ONE_C;
                if (cnt_q == LAST_C) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    res_d   = prod_sgn[N_BITS-1:0];
                    ovf_d   = prod_ovf(prod_sgn);
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        zero_d = (res_d == '0);
        neg_d  = res_d[N_BITS-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    // Multiplier datapath: only meaningful while in S_MUL, so no reset.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        prod_q   <= prod_d;
        sign_q   <= sign_d;
    end

    assign busy   = (state_q == S_MUL);
    assign done   = done_q;
    assign Saida  = res_q;
    assign FLAG_O = ovf_q;
    assign ZERO   = zero_q;
    assign NEG    = neg_q;

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Registered, parametrised-width signed ALU for the LOAC datapath. Successor to the 8-bit combinational ULA.
- Adds XOR, a multi-cycle signed multiply and an accumulate mode.
- Flags are correct two's-complement: overflow, zero, negative.
- Uses a start/busy/done handshake. Results and flags are held in registers until the next operation completes.

Parameters:
- N_BITS, 8, operand/result width in bits (N_BITS >= 4); A, B and Saida are two's-complement signed.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled on rising edge; latches A, B, F
- A  in  N_BITS  signed operand A
- B  in  N_BITS  signed operand B
- F  in  3  operation select
- busy  out  1  high while a multiply is in progress
- done  out  1  one-cycle pulse when Saida/flags are updated
- Saida  out  N_BITS  registered result
- FLAG_O  out  1  registered signed overflow of last operation
- ZERO  out  1  registered, Saida == 0
- NEG  out  1  registered, Saida[N_BITS-1]

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- On reset: Saida=0, FLAG_O=0, ZERO=1, NEG=0, busy=0, done=0, FSM=IDLE, multiply counter=0. Reset wins over start.
- Reset during a multiply aborts it: no done pulse, and the result is discarded.
- Operation encoding (F):
  - 000 AND
  - 001 OR
  - 010 ADD A+B
  - 011 SUB A-B
  - 100 XOR
  - 101 MUL A*B, signed, low N_BITS of the product
  - 110 ACC Saida+A, using the current registered Saida
  - 111 reserved: result 0, FLAG_O=0
- Overflow rules (s = result MSB, a/b = operand MSBs):
  - ADD: a==b and s!=a.
  - SUB: a!=b and s!=a.
  - ACC: same as ADD, with Saida as the first operand.
  - MUL: FLAG_O=1 iff the full 2*N_BITS signed product is not representable in N_BITS signed bits (upper N_BITS+1 bits not all equal).
  - Logic ops and reserved: FLAG_O=0.
  - Results wrap modulo 2^N_BITS.
- ZERO and NEG are always derived from the new Saida value in the same update.
- FSM IDLE, single-cycle ops (F != 101):
  - start high at edge k → Saida/flags updated at edge k; done=1 for the following cycle only.
  - FSM stays in IDLE; busy stays 0. Latency 1.
  - Back-to-back starts on consecutive edges are legal; each produces its own done pulse.
- FSM IDLE → MUL (F = 101):
  - At start edge k: latch |A| and |B| as N_BITS-bit unsigned magnitudes (the most-negative value maps correctly), the result sign = a XOR b, and clear the 2N-bit partial product.
  - busy=1 from edge k.
- FSM MUL:
  - One shift-add iteration per edge, N_BITS iterations in total.
  - At the final iteration edge k+N_BITS: apply the sign, write Saida/flags, set busy=0, done=1 for one cycle, return to IDLE.
  - Saida and flags hold their previous values throughout the multiply.
- Handshake rules:
  - start while busy=1 is ignored; operands are not re-latched.
  - A, B and F may change freely after the start edge.
  - Outputs hold indefinitely while idle.

Test Plan:
- Signed-add overflow (N_BITS=8): reset, then ADD A=100, B=50 → after 1 edge Saida=0x96 (-106), FLAG_O=1, NEG=1, ZERO=0, done pulses once; ADD A=-3, B=3 → Saida=0, ZERO=1, FLAG_O=0.
- Subtract and logic ops: SUB A=-128, B=1 → Saida=0x7F, FLAG_O=1; SUB A=5, B=7 → Saida=0xFE, FLAG_O=0, NEG=1; AND 0xF0,0x3C → 0x30; OR → 0xFC; XOR → 0xCC, FLAG_O=0 for all three.
- Multiply: MUL A=12, B=-10 → busy high for 8 cycles, then Saida=0x88 (-120), FLAG_O=0, done one cycle; MUL 16*8 → Saida=0x80, FLAG_O=1; MUL -128*-1 → Saida=0x80, FLAG_O=1.
- Accumulate: reset, then ACC A=5 three times back-to-back → Saida 5, 10, 15 with three done pulses; ACC A=120 from 15 → Saida=0x87, FLAG_O=1.
- Handshake during busy: start MUL 3*4; assert start with ADD 1+1 on cycle 3 → ignored; result Saida=12 after 8 cycles and exactly one done pulse.
- Reset mid-multiply: reset asserted on cycle 4 of a MUL → next cycle all outputs at reset values, busy=0, no done pulse; a new ADD 2+2 then gives Saida=4.
